// File: rtl/edge_pulse_stretcher.sv
// Edge detector for a registered control bit: rise/fall pulses,
// a retriggerable stretched pulse and a saturating rise counter.
module edge_pulse_stretcher #(
  parameter int unsigned STRETCH_LEN = 8,
  parameter int unsigned CNT_WIDTH   = 16
) (
  input  logic                 CLOCK,
  input  logic                 RESET_N,
  input  logic                 DIN,
  input  logic                 CLEAR,
  output logic                 RISE,
  output logic                 FALL,
  output logic                 STRETCH,
  output logic [CNT_WIDTH-1:0] EDGE_COUNT,
  output logic                 SATURATED
);

  localparam logic [7:0] LOAD = 8'(STRETCH_LEN - 1);

  typedef enum logic {
    IDLE,
    ACTIVE
  } state_t;

  logic                 r_d_q;
  logic                 r_armed;
  state_t               r_state;
  logic [7:0]           r_cnt;
  logic                 w_rise;
  logic                 w_fall;
  logic [CNT_WIDTH-1:0] w_cnt_nxt;

  // armed masks the first sample after reset so a held-high DIN is not an edge
  assign w_rise = r_armed & DIN & ~r_d_q;
  assign w_fall = r_armed & ~DIN & r_d_q;

  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_d_q   <= 1'b0;
      r_armed <= 1'b0;
      RISE    <= 1'b0;
      FALL    <= 1'b0;
    end else begin
      r_d_q   <= DIN;
      r_armed <= 1'b1;
      RISE    <= w_rise;
      FALL    <= w_fall;
    end
  end

  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      STRETCH <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (w_rise) begin
            r_cnt   <= LOAD;
            STRETCH <= 1'b1;
            r_state <= ACTIVE;
          end
        end
        ACTIVE: begin
          if (w_rise) begin
            r_cnt <= LOAD;
          end else if (r_cnt == 8'd0) begin
            STRETCH <= 1'b0;
            r_state <= IDLE;
          end else begin
            r_cnt <= r_cnt - 8'd1;
          end
        end
        default: begin
          STRETCH <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  // a rise coinciding with CLEAR counts as the first edge after the clear
  always_comb begin
    w_cnt_nxt = EDGE_COUNT;
    if (CLEAR) begin
      w_cnt_nxt = CNT_WIDTH'(w_rise);
    end else if (w_rise && !(&EDGE_COUNT)) begin
      w_cnt_nxt = EDGE_COUNT + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      EDGE_COUNT <= '0;
      SATURATED  <= 1'b0;
    end else begin
      EDGE_COUNT <= w_cnt_nxt;
      SATURATED  <= &w_cnt_nxt;
    end
  end

endmodule

// File: tb/tb_edge_pulse_stretcher.sv
// Randomised scoreboard bench for edge_pulse_stretcher, with two
// instances: default sizing and STRETCH_LEN=1 / CNT_WIDTH=4.
module tb_edge_pulse_stretcher;

  logic clk;
  logic rst_n;
  logic din;
  logic clr;

  logic        rise_a, fall_a, st_a, sat_a;
  logic [15:0] cnt_a;
  logic        rise_b, fall_b, st_b, sat_b;
  logic [3:0]  cnt_b;

  edge_pulse_stretcher #(.STRETCH_LEN(8), .CNT_WIDTH(16)) dut_a (
    .CLOCK(clk), .RESET_N(rst_n), .DIN(din), .CLEAR(clr),
    .RISE(rise_a), .FALL(fall_a), .STRETCH(st_a),
    .EDGE_COUNT(cnt_a), .SATURATED(sat_a)
  );

  edge_pulse_stretcher #(.STRETCH_LEN(1), .CNT_WIDTH(4)) dut_b (
    .CLOCK(clk), .RESET_N(rst_n), .DIN(din), .CLEAR(clr),
    .RISE(rise_b), .FALL(fall_b), .STRETCH(st_b),
    .EDGE_COUNT(cnt_b), .SATURATED(sat_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        rise;
    logic        fall;
    logic        st_a;
    logic        st_b;
    logic [15:0] cnt_a;
    logic        sat_a;
    logic [3:0]  cnt_b;
    logic        sat_b;
  } exp_t;

  exp_t q[$];
  int total = 0;
  int bad   = 0;
  int sb_checks = 0;

  task automatic chk(input string name, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, got, want);
    end
  endtask

  // Reference model: edges counted from the history of sampled DIN
  int cyc;
  bit prev;
  int last_rise;
  int rises;

  function automatic int sat_min(input int n, input int w);
    int top;
    top = (1 << w) - 1;
    return (n > top) ? top : n;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    exp_t e;
    bit r, f;
    if (!rst_n) begin
      cyc = 0;
      prev = 1'b0;
      last_rise = -1;
      rises = 0;
      q.delete();
    end else begin
      r = (cyc > 0) && din && !prev;
      f = (cyc > 0) && !din && prev;
      if (r) last_rise = cyc;
      if (clr) rises = r ? 1 : 0;
      else rises = rises + (r ? 1 : 0);
      e.rise  = r;
      e.fall  = f;
      e.st_a  = (last_rise >= 0) && (cyc - last_rise < 8);
      e.st_b  = (last_rise >= 0) && (cyc - last_rise < 1);
      e.cnt_a = 16'(sat_min(rises, 16));
      e.sat_a = (rises >= 65535);
      e.cnt_b = 4'(sat_min(rises, 4));
      e.sat_b = (rises >= 15);
      q.push_back(e);
      prev = din;
      cyc++;
    end
  end

  // Monitor: outputs are valid every clock while out of reset
  always @(posedge clk) begin
    exp_t e, g;
    #1;
    if (rst_n) begin
      g = '{rise_a, fall_a, st_a, st_b, cnt_a, sat_a, cnt_b, sat_b};
      total++;
      sb_checks++;
      if (q.size() == 0) begin
        bad++;
        $display("FAIL sb_underflow: no expected entry at t=%0t", $time);
      end else begin
        e = q.pop_front();
        if (g != e || rise_b != e.rise || fall_b != e.fall) begin
          bad++;
          $display("FAIL sb t=%0t: got r%0b f%0b sa%0b sb%0b ca%0d pa%0b cb%0d pb%0b rb%0b fb%0b want r%0b f%0b sa%0b sb%0b ca%0d pa%0b cb%0d pb%0b",
            $time, rise_a, fall_a, st_a, st_b, cnt_a, sat_a, cnt_b, sat_b,
            rise_b, fall_b, e.rise, e.fall, e.st_a, e.st_b, e.cnt_a,
            e.sat_a, e.cnt_b, e.sat_b);
        end
      end
    end
  end

  task automatic step(input bit d, input bit c);
    @(negedge clk);
    din = d;
    clr = c;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_rise"},  int'(rise_a | rise_b), 0);
    chk({tag, "_fall"},  int'(fall_a | fall_b), 0);
    chk({tag, "_st"},    int'(st_a | st_b), 0);
    chk({tag, "_cnt_a"}, int'(cnt_a), 0);
    chk({tag, "_cnt_b"}, int'(cnt_b), 0);
    chk({tag, "_sat"},   int'(sat_a | sat_b), 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk_reset_vals("async_rst");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    din   = 1'b1;
    clr   = 1'b0;
    #1 chk_reset_vals("por");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // DIN high at release: no rise, then one fall
    repeat (5) step(1'b1, 1'b0);
    repeat (3) step(1'b0, 1'b0);

    // single rise, then retrigger inside the stretch
    step(1'b1, 1'b0);
    repeat (3) step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    repeat (12) step(1'b1, 1'b0);
    repeat (2) step(1'b0, 1'b0);

    // toggling every cycle
    for (int i = 0; i < 20; i++) step(1'(~i[0]), 1'b0);
    step(1'b0, 1'b0);

    // saturate the 4-bit counter, then clear with a rise
    step(1'b0, 1'b1);
    for (int i = 0; i < 17; i++) begin
      step(1'b1, 1'b0);
      step(1'b0, 1'b0);
    end
    @(posedge clk);
    #2 chk("sat_b_17", int'(sat_b), 1);
    chk("cnt_b_17", int'(cnt_b), 15);
    step(1'b1, 1'b1);
    step(1'b1, 1'b0);
    #2 chk("clr_rise_cnt_b", int'(cnt_b), 1);

    // reset in the middle of a stretch with DIN held high
    step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    repeat (2) step(1'b1, 1'b0);
    #1 chk("pre_rst_st", int'(st_a), 1);
    do_reset();
    repeat (6) step(1'b1, 1'b0);

    // random traffic with occasional clears and resets
    for (int i = 0; i < 3000; i++) begin
      step(1'(($urandom_range(0, 3) == 0) ? ~din : din),
           1'($urandom_range(0, 39) == 0));
      if ($urandom_range(0, 499) == 0) do_reset();
    end
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0);

    chk("sb_activity", int'(sb_checks > 3000), 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/edge_pulse_stretcher.md
Name: edge_pulse_stretcher

Overview:
Consumes the registered single-bit control signal produced by the one-bit pipeline register stage (DIN is that register's DOUT). It detects rising and falling edges and emits one-cycle edge pulses. It also produces a retriggerable stretched pulse and keeps a saturating count of rising edges. Downstream fitter control logic uses it for hold/start handshakes and for diagnostics.

Parameters:
STRETCH_LEN, 8, number of cycles STRETCH stays high after the most recent rising edge; legal range 1..255.
CNT_WIDTH, 16, width of EDGE_COUNT.

Ports:
CLOCK  input  1  single system clock, all logic on rising edge
RESET_N  input  1  asynchronous active-low reset
DIN  input  1  registered control bit from upstream register stage; already synchronous to CLOCK
CLEAR  input  1  synchronous clear of EDGE_COUNT and SATURATED
RISE  output  1  one-cycle pulse per 0->1 transition of DIN
FALL  output  1  one-cycle pulse per 1->0 transition of DIN
STRETCH  output  1  high for STRETCH_LEN cycles after the latest rise
EDGE_COUNT  output  CNT_WIDTH  saturating count of rising edges
SATURATED  output  1  high while EDGE_COUNT is all ones

Behaviour:
- Reset (RESET_N low, asynchronous): RISE=0, FALL=0, STRETCH=0, EDGE_COUNT=0, SATURATED=0. Internal d_q=0, armed=0, stretch counter=0, FSM=IDLE. Outputs hold these values while RESET_N is low.
- Edge sampling: d_q <= DIN on every clock edge.
  - armed goes to 1 on the first clock after reset release.
  - No edge is reported on that first clock. DIN already high at reset release produces no RISE.
- Edge outputs, registered, 1-cycle latency:
  - RISE <= armed & DIN & ~d_q
  - FALL <= armed & ~DIN & d_q
  - At clock edge k, DIN first samples 1 -> RISE is high during cycle k+1 only.
  - Alternating DIN each cycle produces alternating RISE/FALL pulses. RISE and FALL are never high together.
- Stretch FSM, states IDLE and ACTIVE:
  - A rise detected at edge k (the same condition that sets RISE) -> STRETCH high from cycle k+1; counter loaded with STRETCH_LEN-1; state ACTIVE.
  - In ACTIVE, each clock edge: if counter==0 -> STRETCH=0, state IDLE; else counter decrements.
  - STRETCH is therefore high for exactly STRETCH_LEN cycles.
  - A rise detected while ACTIVE reloads the counter to STRETCH_LEN-1, so STRETCH stays high STRETCH_LEN cycles from the latest rise with no gap.
  - STRETCH_LEN=1 -> STRETCH is identical to RISE.
  - Falls do not affect the FSM.
- Counter:
  - Each detected rise increments EDGE_COUNT unless it is all ones, in which case it holds and SATURATED=1.
  - SATURATED is registered together with EDGE_COUNT.
- CLEAR:
  - Synchronous; on the next edge EDGE_COUNT=0 and SATURATED=0.
  - CLEAR with a simultaneous detected rise -> EDGE_COUNT=1.
  - CLEAR has no effect on RISE, FALL or STRETCH.
- Reset mid-stretch: STRETCH drops immediately (asynchronously), FSM returns to IDLE, armed=0.

Test Plan:
1. Reset release with DIN=1 held -> RISE never pulses, STRETCH=0, EDGE_COUNT=0. Then DIN 1->0 -> one FALL pulse.
2. STRETCH_LEN=8; DIN 0->1 sampled at edge 10 -> RISE high cycle 11 only; STRETCH high cycles 11-18; EDGE_COUNT=1.
3. Second rise detected at edge 14 during stretch -> STRETCH stays high continuously through cycle 22; EDGE_COUNT=2.
4. DIN toggling every cycle for 20 cycles -> 10 RISE and 10 FALL one-cycle pulses, never overlapping; EDGE_COUNT=10.
5. CNT_WIDTH=4; 17 rises -> EDGE_COUNT=15 with SATURATED=1 after the 15th rise. CLEAR together with the 18th rise -> EDGE_COUNT=1, SATURATED=0.
6. RESET_N asserted mid-stretch (cycle 3 of 8) -> STRETCH, RISE and EDGE_COUNT go to 0 without a clock. After release, DIN still high -> no RISE.
